fetch_prefetch_queue: RTL and testbench

Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register. It issues sequential fetch requests to an instruction memory with variable latency and buffers the returned instructions, each paired with its PC, in a small in-order queue. It presents one instruction per cycle to the decode stage through a valid/ready handshake. On a branch or jump redirect it flushes the queue and discards any responses still in flight.

---
 rtl/fetch_prefetch_queue_pkg.sv | 19 +
 rtl/fetch_prefetch_queue_if.sv | 41 ++++
 rtl/fetch_prefetch_queue_fifo.sv | 49 ++++
 rtl/fetch_prefetch_queue.sv | 91 +++++++++
 tb/tb_fetch_prefetch_queue.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared types and constants for the fetch prefetch queue.
// Imported by the interface, the FIFO and the top level.
package fetch_prefetch_queue_pkg;

  localparam logic [31:0] PC_STEP = 32'd4;
  localparam int unsigned INSTR_W = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Instruction memory and decode-side bundle of the fetch front end.
// master = fetch unit, slave = memory/decode environment.
interface fetch_prefetch_queue_if;
  import fetch_prefetch_queue_pkg::*;

  logic               imem_req_o;
  logic [31:0]        imem_addr_o;
  logic               imem_gnt_i;
  logic               imem_rvalid_i;
  logic [INSTR_W-1:0] imem_rdata_i;

  logic               instr_valid_o;
  logic [INSTR_W-1:0] instr_o;
  logic [31:0]        pc_o;
  logic               instr_ready_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i,
    output instr_valid_o,
    output instr_o,
    output pc_o,
    input  instr_ready_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i,
    input  instr_valid_o,
    input  instr_o,
    input  pc_o,
    output instr_ready_i
  );

endinterface

// File: rtl/fetch_prefetch_queue_fifo.sv
// Show-ahead FIFO holding {pc, instr} pairs for the fetch queue.
// Flush clears pointers; storage is reset so the head reads 0.
module fetch_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] head_o,
  output logic         empty_o,
  output logic [AW:0]  count_o
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_i) rd_ptr <= rd_ptr + AW'(1);
      if (push_i && !pop_i) count <= count + (AW+1)'(1);
      else if (!push_i && pop_i) count <= count - (AW+1)'(1);
    end
  end

  assign head_o  = mem[rd_ptr];
  assign empty_o = (count == '0);
  assign count_o = count;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch front end: credit-limited sequential requests, in-order
// response queue, redirect flush with in-flight response dropping.
module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   redirect_i,
  input  logic [31:0]            redirect_pc_i,
  fetch_prefetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e       state_q, state_d;
  logic [31:0]  fetch_pc_q, resp_pc_q, target;
  logic [CW-1:0] outst_q, drop_q, count;
  logic [CW:0]  credit;
  logic         empty, req, grant, rvalid, push, valid, pop;
  fetch_entry_t wdata, head;

  assign target = redirect_pc_i & ~32'h3;
  assign credit = {1'b0, count} + {1'b0, outst_q};
  assign rvalid = bus.imem_rvalid_i;

  assign req   = (state_q == RUN) && !redirect_i
              && (credit < (CW+1)'(DEPTH));
  assign grant = req && bus.imem_gnt_i;
  // Credits reserve a slot per request, so a push never sees a full queue.
  assign push  = rvalid && (drop_q == '0) && !redirect_i;
  assign valid = !empty && !redirect_i;
  assign pop   = valid && bus.instr_ready_i;
  assign wdata = '{pc: resp_pc_q, instr: bus.imem_rdata_i};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_i) state_d = RUN;
      RUN:  if (!start_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      state_q <= state_d;
      outst_q <= outst_q + CW'(grant) - CW'(rvalid);
      if (redirect_i) begin
        fetch_pc_q <= target;
        resp_pc_q  <= target;
        drop_q     <= outst_q - CW'(rvalid);
      end else begin
        if (grant) fetch_pc_q <= fetch_pc_q + PC_STEP;
        if (push) resp_pc_q <= resp_pc_q + PC_STEP;
        if (rvalid && drop_q != '0) drop_q <= drop_q - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .data_i  (wdata),
    .head_o  (head),
    .empty_o (empty),
    .count_o (count)
  );

  assign bus.imem_req_o    = req;
  assign bus.imem_addr_o   = fetch_pc_q;
  assign bus.instr_valid_o = valid;
  assign bus.instr_o       = head.instr;
  assign bus.pc_o          = head.pc;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Randomized bench for fetch_prefetch_queue against a request-level
// model: in-flight request list plus expected decode queue.
module tb_fetch_prefetch_queue;
  import fetch_prefetch_queue_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] redir_pc = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  pend_t       pend[$];
  ent_t        q[$];
  logic [31:0] fpc = 32'h0;
  bit          run = 1'b0;

  fetch_prefetch_queue_if bus();

  fetch_prefetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .start_i       (start),
    .redirect_i    (redir),
    .redirect_pc_i (redir_pc),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] pick_target();
    case ($urandom_range(3, 0))
      0: return 32'h0000_0100;
      1: return 32'h0000_0103;
      2: return 32'hFFFF_FFF8;
      default: return $urandom();
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req"}, 32'(bus.imem_req_o), 32'h0);
    check({tag, "_addr"}, bus.imem_addr_o, 32'h0);
    check({tag, "_valid"}, 32'(bus.instr_valid_o), 32'h0);
    check({tag, "_instr"}, bus.instr_o, 32'h0);
    check({tag, "_pc"}, bus.pc_o, 32'h0);
  endtask

  task automatic cycle(input int lat_lo, input int lat_hi,
                       input int gnt_pct, input int rdy_pct,
                       input int redir_pct, input int start_pct);
    bit    exp_req, exp_valid, grant, pop, rv, gnt, rdy;
    pend_t p;
    @(negedge clk);
    start    = int'($urandom_range(99, 0)) < start_pct;
    gnt      = int'($urandom_range(99, 0)) < gnt_pct;
    rdy      = int'($urandom_range(99, 0)) < rdy_pct;
    redir    = int'($urandom_range(99, 0)) < redir_pct;
    redir_pc = pick_target();
    rv = (pend.size() > 0) && (pend[0].due <= cyc + 1);
    bus.imem_gnt_i    = gnt;
    bus.instr_ready_i = rdy;
    bus.imem_rvalid_i = rv;
    if (rv) bus.imem_rdata_i = mem_word(pend[0].addr);
    else bus.imem_rdata_i = $urandom();
    #1;
    exp_req   = run && !redir && (q.size() + pend.size() < DEPTH);
    exp_valid = (q.size() > 0) && !redir;
    check("req", 32'(bus.imem_req_o), 32'(exp_req));
    check("addr", bus.imem_addr_o, fpc);
    check("valid", 32'(bus.instr_valid_o), 32'(exp_valid));
    if (exp_valid) begin
      check("head_pc", bus.pc_o, q[0].pc);
      check("head_instr", bus.instr_o, q[0].ins);
    end
    @(posedge clk);
    cyc++;
    grant = exp_req && gnt;
    pop   = exp_valid && rdy;
    if (redir) begin
      q.delete();
      if (rv) pend.delete(0);
      foreach (pend[i]) pend[i].stale = 1'b1;
      fpc = redir_pc & ~32'h3;
    end else begin
      if (pop) q.delete(0);
      if (rv) begin
        p = pend[0];
        pend.delete(0);
        if (!p.stale) q.push_back('{p.addr, mem_word(p.addr)});
      end
      if (grant) begin
        pend.push_back('{fpc, cyc + int'($urandom_range(lat_hi, lat_lo)), 1'b0});
        fpc = fpc + 32'd4;
      end
    end
    run = start;
  endtask

  task automatic reset_mid();
    #2 rst_n = 1'b0;
    #1 check_reset("mid_reset");
    start = 1'b0;
    redir = 1'b0;
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.instr_ready_i = 1'b0;
    q.delete();
    pend.delete();
    fpc = 32'h0;
    run = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = '0;
    bus.instr_ready_i = 1'b0;
    #2 check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40)  cycle(1, 1, 100, 100, 0, 100);
    repeat (30)  cycle(1, 1, 100, 0, 0, 100);
    repeat (30)  cycle(1, 2, 100, 100, 0, 100);
    repeat (300) cycle(3, 3, 100, 100, 8, 100);
    repeat (300) cycle(1, 4, 70, 70, 5, 95);
    reset_mid();
    repeat (40)  cycle(1, 1, 100, 100, 0, 100);
    repeat (600) cycle(1, 5, 60, 60, 6, 90);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
